// File: rtl/cmp_result_monitor_if.sv
// cmp_result_monitor_if: comparator flag stream in, filtered relation and counters out
interface cmp_result_monitor_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             gt;
    logic             eq;
    logic             lt;
    logic             clear;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [1:0]       state;
    logic             change;
    logic             err;

    modport master (
        output in_valid, gt, eq, lt, clear,
        input  gt_cnt, eq_cnt, lt_cnt, state, change, err
    );

    modport slave (
        input  in_valid, gt, eq, lt, clear,
        output gt_cnt, eq_cnt, lt_cnt, state, change, err
    );
endinterface

// File: rtl/cmp_result_monitor.sv
// cmp_result_monitor: qualifies comparator flags, counts relations, debounces them into a stable state
module cmp_result_monitor #(
    parameter int CNT_W   = 8,
    parameter int PERSIST = 3
) (
    input logic                  clk,
    input logic                  rst,
    cmp_result_monitor_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, EQ = 2'b01, GT = 2'b10, LT = 2'b11} rel_e;

    localparam int             RW      = $clog2(PERSIST + 1);
    localparam logic [RW-1:0]  RUN_MAX = RW'(PERSIST);

    rel_e             state_q, state_d, cand_q, cand_d, samp;
    logic [RW-1:0]    run_q, run_d;
    logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d, eq_cnt_q, eq_cnt_d, lt_cnt_q, lt_cnt_d;
    logic             change_q, change_d, err_q, err_d;
    logic             one_hot, accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return &c ? c : c + CNT_W'(1);
    endfunction

    // sample qualification, saturating counters, streak tracking and sticky error
    always_comb begin
        one_hot  = (bus.gt ^ bus.eq ^ bus.lt) & ~(bus.gt & bus.eq & bus.lt);
        accept   = bus.in_valid & one_hot;
        samp     = bus.gt ? GT : (bus.eq ? EQ : LT);
        gt_cnt_d = (accept && bus.gt) ? sat_inc(gt_cnt_q) : gt_cnt_q;
        eq_cnt_d = (accept && bus.eq) ? sat_inc(eq_cnt_q) : eq_cnt_q;
        lt_cnt_d = (accept && bus.lt) ? sat_inc(lt_cnt_q) : lt_cnt_q;
        err_d    = err_q | (bus.in_valid & ~one_hot);
        cand_d   = accept ? samp : cand_q;
        run_d    = !accept ? run_q :
                   (samp != cand_q) ? RW'(1) :
                   (run_q == RUN_MAX) ? run_q : run_q + RW'(1);
        if (bus.clear) begin
            gt_cnt_d = '0;
            eq_cnt_d = '0;
            lt_cnt_d = '0;
            err_d    = 1'b0;
            cand_d   = IDLE;
            run_d    = '0;
        end
    end

    // persistence FSM: move to the candidate once it has been seen PERSIST times in a row
    always_comb begin
        state_d  = state_q;
        change_d = 1'b0;
        if (accept && run_d == RUN_MAX && cand_d != state_q) begin
            state_d  = cand_d;
            change_d = 1'b1;
        end
        if (bus.clear) begin
            state_d  = IDLE;
            change_d = 1'b0;
        end
    end

    // FSM state register and change pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            change_q <= change_d;
        end
    end

    // counter, streak and error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gt_cnt_q <= '0;
            eq_cnt_q <= '0;
            lt_cnt_q <= '0;
            err_q    <= 1'b0;
            cand_q   <= IDLE;
            run_q    <= '0;
        end else begin
            gt_cnt_q <= gt_cnt_d;
            eq_cnt_q <= eq_cnt_d;
            lt_cnt_q <= lt_cnt_d;
            err_q    <= err_d;
            cand_q   <= cand_d;
            run_q    <= run_d;
        end
    end

    assign bus.gt_cnt = gt_cnt_q;
    assign bus.eq_cnt = eq_cnt_q;
    assign bus.lt_cnt = lt_cnt_q;
    assign bus.state  = state_q;
    assign bus.change = change_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_cmp_result_monitor.sv
// tb_cmp_result_monitor: directed checks of counting, persistence filtering, error, clear and reset
module tb_cmp_result_monitor;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    cmp_result_monitor_if #(.CNT_W(8)) b0 ();
    cmp_result_monitor_if #(.CNT_W(4)) b1 ();

    cmp_result_monitor #(.CNT_W(8), .PERSIST(3)) u0 (.clk(clk), .rst(rst), .bus(b0));
    cmp_result_monitor #(.CNT_W(4), .PERSIST(1)) u1 (.clk(clk), .rst(rst), .bus(b1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic g, input logic e, input logic l, input logic c);
        @(negedge clk);
        b0.in_valid = v; b0.gt = g; b0.eq = e; b0.lt = l; b0.clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc1(input logic v, input logic g, input logic e, input logic l);
        @(negedge clk);
        b1.in_valid = v; b1.gt = g; b1.eq = e; b1.lt = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        b0.in_valid = 0; b0.gt = 0; b0.eq = 0; b0.lt = 0; b0.clear = 0;
        b1.in_valid = 0; b1.gt = 0; b1.eq = 0; b1.lt = 0; b1.clear = 0;
        #1 rst = 1'b1;
        #1;
        chk("rst_state", b0.state, 0);
        chk("rst_gt", b0.gt_cnt, 0);
        chk("rst_change", b0.change, 0);
        chk("rst_err", b0.err, 0);
        @(negedge clk); rst = 1'b0;
        // three GT samples reach the GT state
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("gt2_state", b0.state, 2'b00);
        chk("gt2_cnt", b0.gt_cnt, 2);
        cyc(1, 1, 0, 0, 0);
        chk("gt3_state", b0.state, 2'b10);
        chk("gt3_change", b0.change, 1);
        chk("gt3_cnt", b0.gt_cnt, 3);
        cyc(1, 1, 0, 0, 0);
        chk("gt4_state", b0.state, 2'b10);
        chk("gt4_change", b0.change, 0);
        chk("gt4_cnt", b0.gt_cnt, 4);
        // GT to LT transition
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        chk("lt2_state", b0.state, 2'b10);
        cyc(1, 0, 0, 1, 0);
        chk("lt3_state", b0.state, 2'b11);
        chk("lt3_change", b0.change, 1);
        chk("lt3_cnt", b0.lt_cnt, 3);
        // clear drops everything
        cyc(0, 0, 0, 0, 1);
        chk("clr_state", b0.state, 0);
        chk("clr_change", b0.change, 0);
        chk("clr_gt", b0.gt_cnt, 0);
        chk("clr_lt", b0.lt_cnt, 0);
        // GT,GT,EQ,GT,GT,GT
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("brk5_state", b0.state, 0);
        cyc(1, 1, 0, 0, 0);
        chk("brk6_state", b0.state, 2'b10);
        chk("brk6_gt", b0.gt_cnt, 5);
        chk("brk6_eq", b0.eq_cnt, 1);
        // gaps hold the streak
        cyc(0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("gap2_state", b0.state, 0);
        cyc(1, 1, 0, 0, 0);
        chk("gap3_state", b0.state, 2'b10);
        // illegal patterns set sticky err
        cyc(0, 0, 0, 0, 1);
        cyc(1, 1, 0, 1, 0);
        chk("ill_err", b0.err, 1);
        chk("ill_gt", b0.gt_cnt, 0);
        chk("ill_lt", b0.lt_cnt, 0);
        cyc(1, 0, 1, 0, 0);
        chk("ill_err_sticky", b0.err, 1);
        chk("ill_eq", b0.eq_cnt, 1);
        cyc(1, 0, 0, 0, 0);
        chk("ill000_eq", b0.eq_cnt, 1);
        chk("ill000_err", b0.err, 1);
        cyc(0, 0, 0, 0, 1);
        chk("ill_clr_err", b0.err, 0);
        // async reset mid-streak
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        b0.in_valid = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst_gt", b0.gt_cnt, 0);
        chk("arst_state", b0.state, 0);
        @(negedge clk); rst = 1'b0;
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("arst2_state", b0.state, 0);
        cyc(1, 1, 0, 0, 0);
        chk("arst3_state", b0.state, 2'b10);
        chk("arst3_gt", b0.gt_cnt, 3);
        // clear beats a same-cycle valid sample
        cyc(1, 1, 0, 0, 1);
        chk("clrv_gt", b0.gt_cnt, 0);
        chk("clrv_state", b0.state, 0);
        chk("clrv_change", b0.change, 0);
        cyc(0, 0, 0, 0, 0);
        // PERSIST=1, CNT_W=4 instance
        cyc1(1, 0, 1, 0);
        chk("p1_eq_state", b1.state, 2'b01);
        chk("p1_eq_change", b1.change, 1);
        for (int i = 0; i < 19; i++) cyc1(1, 0, 1, 0);
        chk("p1_eq_sat", b1.eq_cnt, 15);
        chk("p1_eq_hold", b1.change, 0);
        cyc1(1, 1, 0, 0);
        chk("p1_gt_state", b1.state, 2'b10);
        chk("p1_gt_change", b1.change, 1);
        chk("p1_gt_cnt", b1.gt_cnt, 1);
        cyc1(1, 1, 0, 0);
        chk("p1_gt2_change", b1.change, 0);
        cyc1(1, 0, 0, 1);
        chk("p1_lt_state", b1.state, 2'b11);
        chk("p1_lt_change", b1.change, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
